spongent_hash_ctrl: RTL and testbench

Sequencer that drives one spongent core (RATE=8) through a complete hash: state clear, byte-wise absorb, padding, then squeeze of a fixed-length digest. Message bytes arrive on a valid/ready stream; digest bytes leave on a valid/ready stream. Sits between the crypto-unit command logic and the spongent instance, and owns every spongent control pin.

---
 rtl/spongent_hash_ctrl.sv | 139 +++++++++++++
 tb/tb_spongent_hash_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/spongent_hash_ctrl.sv
// spongent_hash_ctrl: sequences one RATE=8 spongent core through clear, absorb, pad and squeeze.
// Optional msg_len byte counter output enabled by SPONGENT_CTRL_MSG_LEN_EN.
module spongent_hash_ctrl #(
    parameter int unsigned DIGEST_BYTES = 16,
    parameter logic [7:0]  PAD_BYTE     = 8'h80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        empty,
    output logic        busy,
    output logic        done,
    input  logic [7:0]  msg_data,
    input  logic        msg_valid,
    input  logic        msg_last,
    output logic        msg_ready,
    output logic [7:0]  dig_data,
    output logic        dig_valid,
    output logic        dig_last,
    input  logic        dig_ready,
    output logic        sp_reset,
    output logic        sp_start_continue,
    output logic        sp_msg_data_available,
    output logic [7:0]  sp_data_in,
    input  logic        sp_busy,
    input  logic [7:0]  sp_data_out
`ifdef SPONGENT_CTRL_MSG_LEN_EN
    ,
    output logic [31:0] msg_len
`endif
);
    typedef enum logic [3:0] {
        IDLE, CLEAR, ABS_WAIT, ABS_GO, ABS_RUN, PAD_GO, PAD_RUN, SQ_OUT, SQ_GO, SQ_RUN
    } state_t;
    state_t state_q, state_d;
    logic guard_q, guard_d, empty_q, empty_d, last_q, last_d;
    logic [7:0] cnt_q, cnt_d, sp_data_in_q, sp_data_in_d, dig_data_q, dig_data_d;
    logic msg_hs, perm_done, is_last;
    assign msg_hs    = state_q == ABS_WAIT && msg_valid;
    // guard_q marks the cycle right after a pulse, where sp_busy may not yet be valid
    assign perm_done = !guard_q && !sp_busy;
    assign is_last   = cnt_q == 8'(DIGEST_BYTES - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            guard_q      <= 1'b0;
            empty_q      <= 1'b0;
            last_q       <= 1'b0;
            cnt_q        <= '0;
            sp_data_in_q <= '0;
            dig_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            guard_q      <= guard_d;
            empty_q      <= empty_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            sp_data_in_q <= sp_data_in_d;
            dig_data_q   <= dig_data_d;
        end
    end
    always_comb begin
        state_d      = state_q;
        guard_d      = 1'b0;
        empty_d      = empty_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        sp_data_in_d = sp_data_in_q;
        dig_data_d   = dig_data_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = CLEAR;
                empty_d = empty;
                cnt_d   = '0;
            end
            CLEAR: begin
                state_d      = empty_q ? PAD_GO : ABS_WAIT;
                sp_data_in_d = empty_q ? PAD_BYTE : sp_data_in_q;
            end
            ABS_WAIT: if (msg_hs) begin
                state_d      = ABS_GO;
                sp_data_in_d = msg_data;
                last_d       = msg_last;
            end
            ABS_GO: begin
                state_d = ABS_RUN;
                guard_d = 1'b1;
            end
            ABS_RUN: if (perm_done) begin
                state_d      = last_q ? PAD_GO : ABS_WAIT;
                sp_data_in_d = last_q ? PAD_BYTE : sp_data_in_q;
            end
            PAD_GO: begin
                state_d = PAD_RUN;
                guard_d = 1'b1;
            end
            PAD_RUN: if (perm_done) begin
                state_d    = SQ_OUT;
                cnt_d      = '0;
                dig_data_d = sp_data_out;
            end
            SQ_OUT: if (dig_ready) begin
                state_d = is_last ? IDLE : SQ_GO;
                cnt_d   = is_last ? cnt_q : cnt_q + 8'd1;
            end
            SQ_GO: begin
                state_d = SQ_RUN;
                guard_d = 1'b1;
            end
            SQ_RUN: if (perm_done) begin
                state_d    = SQ_OUT;
                dig_data_d = sp_data_out;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        busy                  = state_q != IDLE;
        msg_ready             = state_q == ABS_WAIT;
        dig_valid             = state_q == SQ_OUT;
        dig_last              = dig_valid && is_last;
        done                  = dig_last && dig_ready;
        sp_reset              = state_q == CLEAR;
        sp_msg_data_available = state_q == ABS_GO || state_q == PAD_GO;
        sp_start_continue     = sp_msg_data_available || state_q == SQ_GO;
        sp_data_in            = sp_data_in_q;
        dig_data              = dig_data_q;
    end
`ifdef SPONGENT_CTRL_MSG_LEN_EN
    logic [31:0] len_q, len_d;
    always_comb
        len_d = state_q == CLEAR ? '0 : (msg_hs && len_q != '1) ? len_q + 32'd1 : len_q;
    always_ff @(posedge clk) begin
        if (reset) len_q <= '0;
        else       len_q <= len_d;
    end
    assign msg_len = len_q;
`endif
endmodule

// File: tb/tb_spongent_hash_ctrl.sv
// tb_spongent_hash_ctrl: randomized self-checking bench with a stub spongent core whose
// data_out is its permutation count, so every pulse and digest byte is predictable.
module tb_spongent_hash_ctrl;
    logic clk = 0, reset = 1, start = 0, empty = 0;
    logic busy, done, msg_ready, dig_valid, dig_last, sp_reset, sp_start_continue, sp_msg_data_available;
    logic [7:0] msg_data = 0, dig_data, sp_data_in, sp_data_out;
    logic msg_valid = 0, msg_last = 0, dig_ready = 0, sp_busy;
`ifdef SPONGENT_CTRL_MSG_LEN_EN
    logic [31:0] msg_len;
`endif
    int tests = 0, fails = 0;
    always #5 clk = ~clk;

    spongent_hash_ctrl #(.DIGEST_BYTES(16), .PAD_BYTE(8'h80)) dut (
        .clk(clk), .reset(reset), .start(start), .empty(empty), .busy(busy), .done(done),
        .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready),
        .dig_data(dig_data), .dig_valid(dig_valid), .dig_last(dig_last), .dig_ready(dig_ready),
        .sp_reset(sp_reset), .sp_start_continue(sp_start_continue),
        .sp_msg_data_available(sp_msg_data_available), .sp_data_in(sp_data_in),
        .sp_busy(sp_busy), .sp_data_out(sp_data_out)
`ifdef SPONGENT_CTRL_MSG_LEN_EN
        , .msg_len(msg_len)
`endif
    );

    // stub core: 5-cycle busy per pulse, data_out counts permutations since its reset
    logic [7:0] perm;
    int busy_cnt;
    assign sp_busy = busy_cnt != 0;
    assign sp_data_out = perm;
    always @(posedge clk) begin
        if (reset || sp_reset) begin
            perm <= 0;
            busy_cnt <= 0;
        end else if (sp_start_continue) begin
            perm <= perm + 8'd1;
            busy_cnt <= 5;
        end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    logic [8:0] pq[$], dq[$];
    int rst_cnt = 0, done_cnt = 0, mr_cnt = 0, viol = 0;
    always @(negedge clk) begin
        if (sp_start_continue) pq.push_back({sp_msg_data_available, sp_data_in});
        if (sp_start_continue && sp_busy) viol++;
        if (done && !(dig_valid && dig_ready && dig_last)) viol++;
        if (sp_reset) rst_cnt++;
        if (msg_ready) mr_cnt++;
        if (done) done_cnt++;
        if (dig_valid && dig_ready) dq.push_back({dig_last, dig_data});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {busy, done, msg_ready, dig_data, dig_valid, dig_last, sp_reset,
                sp_start_continue, sp_msg_data_available, sp_data_in};
    endfunction

    task automatic run_hash(input int n, input int stall_at, input bit spam, input bit inc);
        logic [7:0] mb[$];
        logic [7:0] held = 0;
        int sent = 0, got = 0, stall = 0, stall_bad = 0;
        bit fin = 0;
        for (int i = 0; i < n; i++) mb.push_back(inc ? 8'(i + 1) : 8'($urandom));
        pq.delete(); dq.delete();
        rst_cnt = 0; done_cnt = 0; mr_cnt = 0;
        @(posedge clk); #1;
        start = 1; empty = (n == 0);
        @(posedge clk); #1;
        start = 0; empty = 0;
        for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
            start = spam && (sp_busy || dig_valid);
            if (sent < n) begin
                msg_valid = ($urandom % 4) != 0;
                msg_data = mb[sent];
                msg_last = msg_valid && sent == n - 1;
            end else begin
                msg_valid = $urandom % 2;
                msg_data = 8'($urandom);
                msg_last = 0;
            end
            if (dig_valid && got == stall_at && stall < 10) begin
                if (stall == 0) held = dig_data;
                dig_ready = 0;
                stall++;
            end else dig_ready = ($urandom % 3) != 0;
            @(negedge clk);
            if (dig_valid && !dig_ready && stall > 0 && stall <= 10 && got == stall_at)
                if (dig_data !== held || sp_start_continue) stall_bad++;
            if (msg_valid && msg_ready && sent < n) sent++;
            if (dig_valid && dig_ready) begin
                got++;
                if (done) fin = 1;
            end
            @(posedge clk); #1;
        end
        start = 0; msg_valid = 0; msg_last = 0; dig_ready = 0;
        check("finished", fin, 1);
        check("busy_after", busy, 0);
        check("sp_reset_cnt", rst_cnt, 1);
        check("done_cnt", done_cnt, 1);
        check("pulse_cnt", pq.size(), n + 16);
        check("digest_cnt", dq.size(), 16);
        if (n == 0) check("msg_ready_empty", mr_cnt, 0);
        for (int i = 0; i < pq.size() && i < n + 16; i++)
            if (i < n) check("absorb_pulse", pq[i], {1'b1, mb[i]});
            else if (i == n) check("pad_pulse", pq[i], 9'h180);
            else check("squeeze_avail", pq[i][8], 0);
        for (int k = 0; k < dq.size() && k < 16; k++)
            check("digest", dq[k], {k == 15, 8'(n + 1 + k)});
        if (stall_at >= 0) begin
            check("stall_len", stall, 10);
            check("stall_hold", stall_bad, 0);
        end
`ifdef SPONGENT_CTRL_MSG_LEN_EN
        check("msg_len", msg_len, n);
`endif
    endtask

    task automatic reset_abort();
        @(posedge clk); #1;
        start = 1; empty = 0;
        @(posedge clk); #1;
        start = 0; msg_valid = 1; msg_data = 8'h5A; msg_last = 1;
        for (int k = 0; k < 50 && !sp_busy; k++) begin
            @(posedge clk); #1;
        end
        msg_valid = 0; msg_last = 0;
        check("abort_reached_run", sp_busy, 1);
        reset = 1;
        @(posedge clk); #1;
        check("abort_outputs", outs(), 0);
        reset = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 0);
        reset = 0;
        run_hash(3, -1, 0, 1);
        run_hash(0, -1, 0, 0);
        run_hash(2, 3, 0, 0);
        run_hash(2, -1, 1, 0);
        reset_abort();
        run_hash(1, -1, 0, 0);
`ifdef SPONGENT_CTRL_MSG_LEN_EN
        run_hash(300, -1, 0, 0);
        run_hash(0, -1, 0, 0);
`endif
        for (int r = 0; r < 6; r++)
            run_hash($urandom_range(0, 6), ($urandom % 2) ? int'($urandom_range(0, 15)) : -1, $urandom % 2, 0);
        check("start_continue_rules", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
